fifo_ctrl: RTL and testbench

//  Pointer/flag controller for the 10-bit x 8 dual-port FIFO memory. Sits directly upstream of

---
 rtl/fifo_defs.sv | 13 +
 rtl/fifo_ptr.sv | 16 +
 rtl/fifo_ctrl.sv | 72 +++++++
 tb/tb_fifo_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_defs.sv
// Shared sizing defaults and the wrapping pointer-increment helper for the FIFO controller.
package fifo_defs;
  localparam int MEM_WIDTH  = 10;
  localparam int MEM_LENGHT = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int PTR_MAX_W  = 16;

  // Callers widen/narrow through PTR_MAX_W so one function serves any ADDR_WIDTH.
  function automatic logic [PTR_MAX_W-1:0] ptr_wrap(input logic [PTR_MAX_W-1:0] p,
                                                    input logic [PTR_MAX_W-1:0] last);
    return (p == last) ? '0 : p + PTR_MAX_W'(1);
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with enable; counts 0..LEN-1 and then returns to 0.
module fifo_ptr
  import fifo_defs::*;
#(
  parameter int AW  = ADDR_WIDTH,
  parameter int LEN = MEM_LENGHT
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          en,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L)  ptr <= '0;
    else if (en)   ptr <= AW'(ptr_wrap(PTR_MAX_W'(ptr), PTR_MAX_W'(LEN - 1)));
endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the dual-port FIFO memory: grants, pointers, occupancy,
// threshold flags, sticky error flags and the read-data valid strobe.
module fifo_ctrl
  import fifo_defs::*;
#(
  parameter int MEM_LENGHT      = fifo_defs::MEM_LENGHT,
  parameter int ADDR_WIDTH      = fifo_defs::ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int RD_LAT = 1;

  logic              wr_ok, rd_ok;
  logic [RD_LAT:1]   vld_pipe;

  // Flags decode only registered count, so no input reaches them combinationally.
  assign fifo_full    = (fifo_count == ADDR_WIDTH'(MEM_LENGHT));
  assign fifo_empty   = (fifo_count == '0);
  assign almost_full  = (fifo_count >= ADDR_WIDTH'(ALMOST_FULL_TH));
  assign almost_empty = (fifo_count <= ADDR_WIDTH'(ALMOST_EMPTY_TH));

  // A full FIFO still takes a push when a pop frees the slot on the same edge.
  assign wr_ok = reset_L & push & (~fifo_full | pop);
  assign rd_ok = reset_L & pop & ~fifo_empty;

  assign write_enable = wr_ok;
  assign read_enable  = rd_ok;
  assign data_valid   = vld_pipe[RD_LAT];

  fifo_ptr #(.AW(ADDR_WIDTH), .LEN(MEM_LENGHT)) u_wr_ptr (
    .clk(clk), .reset_L(reset_L), .en(wr_ok), .ptr(write_addr)
  );

  fifo_ptr #(.AW(ADDR_WIDTH), .LEN(MEM_LENGHT)) u_rd_ptr (
    .clk(clk), .reset_L(reset_L), .en(rd_ok), .ptr(read_addr)
  );

  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      fifo_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   fifo_count <= fifo_count + ADDR_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - ADDR_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push & ~wr_ok) overflow  <= 1'b1;
      if (pop  & ~rd_ok) underflow <= 1'b1;
      vld_pipe[1] <= rd_ok;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench: fifo_ctrl driving a behavioural 10x8 memory, checked against a queue model
// with a scoreboard of expected read data.
module tb_fifo_ctrl;
  localparam int MEM = 8;
  localparam int AW  = 4;
  localparam int AFT = 6;
  localparam int AET = 2;

  logic          clk = 1'b0;
  logic          reset_L, push, pop;
  logic [9:0]    Fifo_Data_in, Fifo_Data_out;
  logic          write_enable, read_enable, data_valid;
  logic [AW-1:0] write_addr, read_addr, fifo_count;
  logic          fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [9:0] model_q[$];
  logic [9:0] exp_q[$];
  int  m_wa, m_ra, m_cnt;
  bit  m_ovf, m_udf, m_dv;

  always #5 clk = ~clk;

  fifo_ctrl #(.MEM_LENGHT(MEM), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AFT), .ALMOST_EMPTY_TH(AET)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
    .write_enable(write_enable), .read_enable(read_enable),
    .write_addr(write_addr), .read_addr(read_addr), .data_valid(data_valid),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // memory with registered read (old data on same-row read/write)
  logic [9:0] mem [MEM];
  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= Fifo_Data_in;
    if (read_enable)  Fifo_Data_out   <= mem[read_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    model_q.delete(); exp_q.delete();
    m_wa = 0; m_ra = 0; m_cnt = 0; m_ovf = 0; m_udf = 0; m_dv = 0;
  endtask

  task automatic chk_state(input string ph);
    chk({ph, ".count"}, fifo_count, m_cnt);
    chk({ph, ".waddr"}, write_addr, m_wa);
    chk({ph, ".raddr"}, read_addr, m_ra);
    chk({ph, ".full"},  fifo_full, m_cnt == MEM);
    chk({ph, ".empty"}, fifo_empty, m_cnt == 0);
    chk({ph, ".afull"}, almost_full, m_cnt >= AFT);
    chk({ph, ".aempty"}, almost_empty, m_cnt <= AET);
    chk({ph, ".ovf"},   overflow, m_ovf);
    chk({ph, ".udf"},   underflow, m_udf);
    chk({ph, ".dvalid"}, data_valid, m_dv);
  endtask

  // One cycle, entered and left on a negedge.
  task automatic cyc(input string ph, input bit p, input bit q, input logic [9:0] d);
    bit ew, er;
    push = p; pop = q; Fifo_Data_in = d;
    #1;
    ew = p && (m_cnt < MEM || q);
    er = q && (m_cnt > 0);
    chk({ph, ".wen"}, write_enable, ew);
    chk({ph, ".ren"}, read_enable, er);
    if (er) begin
      exp_q.push_back(model_q.pop_front());
      m_ra = (m_ra == MEM - 1) ? 0 : m_ra + 1;
    end
    if (ew) begin
      model_q.push_back(d);
      m_wa = (m_wa == MEM - 1) ? 0 : m_wa + 1;
    end
    m_cnt = model_q.size();
    if (p && !ew) m_ovf = 1;
    if (q && !er) m_udf = 1;
    m_dv = er;
    @(negedge clk);
    chk_state(ph);
    if (data_valid) begin
      if (exp_q.size() == 0) chk({ph, ".sb_unexpected"}, 1, 0);
      else chk({ph, ".dout"}, Fifo_Data_out, exp_q.pop_front());
    end
    push = 0; pop = 0;
  endtask

  task automatic do_reset();
    push = 0; pop = 0;
    reset_L = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_L = 1;
  endtask

  logic [9:0] pat [MEM];

  initial begin
    push = 0; pop = 0; Fifo_Data_in = '0; reset_L = 1;
    model_clear();
    for (int i = 0; i < MEM; i++)
      pat[i] = (i % 2 == 0) ? 10'(10'h091 + i) : 10'(10'h04A + i - 1);
    @(negedge clk);

    // 1: reset, grant suppressed while reset is low
    reset_L = 0; push = 1;
    #1 chk("rst.wen_blocked", write_enable, 0);
    push = 0;
    repeat (2) @(negedge clk);
    reset_L = 1;
    #1 chk_state("rst");

    // 2: fill
    for (int i = 0; i < MEM; i++) cyc("fill", 1, 0, pat[i]);
    // 3: overflow, stays set
    cyc("ovf", 1, 0, 10'h3FF);
    cyc("ovf2", 0, 0, 10'h000);
    // 4: drain in order, then underflow
    for (int i = 0; i < MEM; i++) cyc("drain", 0, 1, 10'h000);
    cyc("udf", 0, 1, 10'h000);
    chk("sb.drained", exp_q.size(), 0);

    // 5: simultaneous push&pop at empty, mid, full
    @(negedge clk) do_reset();
    #1 chk_state("rst2");
    cyc("sim_empty", 1, 1, 10'h155);
    cyc("to3", 1, 0, 10'h0AA);
    cyc("to3", 1, 0, 10'h0BB);
    for (int i = 0; i < 4; i++) cyc("sim_mid", 1, 1, 10'(10'h100 + i));
    for (int i = 0; i < 5; i++) cyc("to8", 1, 0, 10'(10'h200 + i));
    cyc("sim_full", 1, 1, 10'h2AA);
    cyc("sim_full2", 1, 1, 10'h2BB);
    for (int i = 0; i < MEM; i++) cyc("drain2", 0, 1, 10'h000);
    chk("sb.drained2", exp_q.size(), 0);

    // 6: async reset between edges at count 5 with data_valid high
    for (int i = 0; i < 6; i++) cyc("to6", 1, 0, 10'(10'h300 + i));
    cyc("to5", 0, 1, 10'h000);
    #2 reset_L = 0;
    #1;
    chk("arst.count", fifo_count, 0);
    chk("arst.empty", fifo_empty, 1);
    chk("arst.dvalid", data_valid, 0);
    chk("arst.waddr", write_addr, 0);
    model_clear();
    @(negedge clk) reset_L = 1;
    cyc("post", 1, 0, 10'h123);
    cyc("post", 0, 1, 10'h000);
    cyc("post", 0, 0, 10'h000);
    chk("sb.final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
